// File: rtl/rf_write_arbiter.sv
// Write-port owner for the 32-entry register file: zero-clears x1..x(2**ADDR_W-1) after reset,
// then round-robin arbitrates two writeback requesters onto registered rf_we/rf_waddr/rf_wdata.
module rf_write_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  typedef enum logic [0:0] {StInit, StArb} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_d;
  logic              init_done_d;

  // rr_ptr names the requester that wins the next conflict.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == StArb) begin
      req0_ready = req0_valid && (!req1_valid || !rr_ptr_q);
      req1_ready = req1_valid && (!req0_valid ||  rr_ptr_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr;
    rf_wdata_d  = rf_wdata;
    init_done_d = init_done;
    unique case (state_q)
      StInit: begin
        // The counter wraps to zero once the top address has been issued.
        if (clr_cnt_q != '0) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = clr_cnt_q;
          rf_wdata_d = '0;
          clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        end else begin
          state_d     = StArb;
          init_done_d = 1'b1;
        end
      end
      StArb: begin
        init_done_d = 1'b1;
        if (req0_ready) begin
          rf_we_d    = (req0_addr != '0);
          rf_waddr_d = req0_addr;
          rf_wdata_d = req0_data;
          rr_ptr_d   = 1'b1;
        end else if (req1_ready) begin
          rf_we_d    = (req1_addr != '0);
          rf_waddr_d = req1_addr;
          rf_wdata_d = req1_data;
          rr_ptr_d   = 1'b0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT_CLEAR ? StInit : StArb;
      clr_cnt_q <= ADDR_W'(1);
      rr_ptr_q  <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      rf_we     <= rf_we_d;
      rf_waddr  <= rf_waddr_d;
      rf_wdata  <= rf_wdata_d;
      init_done <= init_done_d;
    end
  end

endmodule
